ckpt_scheduler: RTL and testbench
=================================

Name: ckpt_scheduler

Overview:
Allocates and tracks branch checkpoint slots for the rename stage. It grants a slot ID to each renamed branch and records which older branches each slot depends on. On branch resolution it either retires the slot or runs a misprediction recovery sequence: it squashes the slot and every younger slot, then blocks allocation while the back end flushes.

Parameters:
N_CHECKPTS, 8, number of checkpoint slots; power of two, 2..16.
TAG_W, $clog2(N_CHECKPTS), slot ID width.
FLUSH_CYCLES, 2, cycles FLUSH state holds after recovery; must be at least 1.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_req_i  in  1  rename wants a slot for a branch this cycle
alloc_gnt_o  out  1  slot granted; combinational
alloc_tag_o  out  TAG_W  granted slot ID; lowest-index free slot
alloc_dep_o  out  N_CHECKPTS  valid mask before this alloc, i.e. the older in-flight branches
res_valid_i  in  1  branch resolution event
res_tag_i  in  TAG_W  resolving slot
res_mispredict_i  in  1  resolution was a mispredict
clear_valid_o  out  1  registered; correct-path slot retired
clear_tag_o  out  TAG_W  slot being cleared
recover_o  out  1  registered one-cycle pulse; restore the checkpoint given by recover_tag_o
recover_tag_o  out  TAG_W  slot to restore
squash_mask_o  out  N_CHECKPTS  slots killed: the resolving slot plus all younger slots
busy_o  out  1  high in RECOVER and FLUSH; allocation is blocked
valid_mask_o  out  N_CHECKPTS  current in-flight slots
full_o  out  1  all slots valid

Behaviour:
- State: valid[N] vector, dep[N][N] matrix (dep[j][k] means slot j is younger than slot k), FSM {IDLE, RECOVER, FLUSH}, flush counter.
- Reset values: valid=0, dep=0, FSM=IDLE. All outputs 0, except alloc_tag_o, which is 0 as the combinational result of an empty valid mask.
- alloc_gnt_o = alloc_req_i && !full_o && state==IDLE && !(res_valid_i && res_mispredict_i).
- On grant, at the clock edge:
  - valid[tag] <= 1.
  - dep[tag] <= valid & ~clear, where clear is the same-cycle correct retirement, if any.
  - alloc_dep_o carries the same value.
- Correct resolution (res_valid_i && !res_mispredict_i && valid[res_tag_i]):
  - valid[t] <= 0 and column dep[*][t] <= 0.
  - Next cycle: clear_valid_o=1, clear_tag_o=t.
  - Allowed in any state, as long as t is not being squashed.
- Mispredict (res_valid_i && res_mispredict_i && valid[t] && state==IDLE):
  - squash = onehot(t) | {j : dep[j][t]}.
  - Next edge: valid <= valid & ~squash; dep rows and columns for squashed slots cleared.
  - FSM -> RECOVER.
- RECOVER lasts 1 cycle:
  - recover_o=1, recover_tag_o=t, squash_mask_o=squash. These are registered, so they appear the cycle after the mispredict.
  - FSM -> FLUSH; counter loads FLUSH_CYCLES-1.
- FLUSH: busy_o=1; counter decrements; -> IDLE when the counter reaches 0.
- Mispredict while in RECOVER or FLUSH:
  - If t is still valid, it must be older than the recovering slot. The slots squashed are those of the new t, and RECOVER re-enters immediately with the new tag.
  - Otherwise the event is ignored.
- Resolution for a slot with valid=0 (already squashed) is ignored. No output changes.
- Same-cycle alloc and correct resolve are both honoured. A freed slot is not re-granted in the same cycle, because the grant uses pre-edge valid.
- Empty: alloc_tag_o=0. Full: alloc_gnt_o=0; rename must stall.
- rst mid-RECOVER/FLUSH: immediately returns to the reset state and recover_o drops on the next edge.

Optional Feature:
Macro CKPT_SCHED_STATS_EN.
- Defined: adds outputs stat_alloc_o, stat_mispredict_o, stat_full_stall_o, each 32 bits.
  - stat_alloc_o counts grants.
  - stat_mispredict_o counts accepted mispredicts.
  - stat_full_stall_o counts cycles with alloc_req_i && full_o.
  - All counters saturate at 2^32-1 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- After reset, 3 allocs in consecutive cycles -> tags 0,1,2; alloc_dep_o = 0x00, 0x01, 0x03; valid_mask_o=0x07.
- 8 allocs then a 9th req -> full_o=1, 9th alloc_gnt_o=0; correct resolve of tag 3 -> next cycle clear_valid_o=1, clear_tag_o=3; next alloc gets tag 3.
- Tags 0..4 valid, mispredict tag 2 -> next cycle recover_o=1, recover_tag_o=2, squash_mask_o=0x1C; valid_mask_o=0x03; busy_o high for 1+FLUSH_CYCLES=3 cycles; alloc blocked throughout.
- During FLUSH, mispredict tag 0 -> re-enter RECOVER, recover_tag_o=0, squash_mask_o=0x03; then resolve for squashed tag 4 -> ignored.
- Same cycle: alloc_req_i with correct resolve of tag 1 while slots 0,1 are valid -> grant tag 2 with alloc_dep_o=0x01.
- Assert rst during FLUSH -> next cycle busy_o=0, valid_mask_o=0, recover_o=0; with CKPT_SCHED_STATS_EN, all stat counters read 0.

Source files
------------

// File: rtl/ckpt_scheduler.sv
// Branch checkpoint slot allocator with dependency tracking and mispredict recovery.
// Define CKPT_SCHED_STATS_EN to add saturating grant/mispredict/full-stall counters.
module ckpt_scheduler #(
  parameter int N_CHECKPTS   = 8,
  parameter int TAG_W        = $clog2(N_CHECKPTS),
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req_i,
  output logic                  alloc_gnt_o,
  output logic [TAG_W-1:0]      alloc_tag_o,
  output logic [N_CHECKPTS-1:0] alloc_dep_o,
  input  logic                  res_valid_i,
  input  logic [TAG_W-1:0]      res_tag_i,
  input  logic                  res_mispredict_i,
  output logic                  clear_valid_o,
  output logic [TAG_W-1:0]      clear_tag_o,
  output logic                  recover_o,
  output logic [TAG_W-1:0]      recover_tag_o,
  output logic [N_CHECKPTS-1:0] squash_mask_o,
  output logic                  busy_o,
  output logic [N_CHECKPTS-1:0] valid_mask_o,
  output logic                  full_o
`ifdef CKPT_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_alloc_o,
  output logic [31:0]           stat_mispredict_o,
  output logic [31:0]           stat_full_stall_o
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [N_CHECKPTS-1:0] ONE = {{(N_CHECKPTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RECOVER, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      flushCnt_q, flushCnt_d;
  logic [N_CHECKPTS-1:0] valid_q, valid_d;
  logic [N_CHECKPTS-1:0] dep_q [N_CHECKPTS];
  logic [N_CHECKPTS-1:0] dep_d [N_CHECKPTS];
  logic                  clearValid_q, clearValid_d;
  logic [TAG_W-1:0]      clearTag_q, clearTag_d;
  logic [TAG_W-1:0]      recoverTag_q, recoverTag_d;
  logic [N_CHECKPTS-1:0] squashMask_q, squashMask_d;

  logic                  full;
  logic                  misReq;
  logic                  clearFire;
  logic                  misFire;
  logic                  gnt;
  logic [TAG_W-1:0]      freeTag;
  logic [N_CHECKPTS-1:0] resOH;
  logic [N_CHECKPTS-1:0] clearOH;
  logic [N_CHECKPTS-1:0] squash;
  logic [N_CHECKPTS-1:0] allocDep;

  assign full      = &valid_q;
  assign misReq    = res_valid_i && res_mispredict_i;
  assign clearFire = res_valid_i && !res_mispredict_i && valid_q[res_tag_i];
  // Any still-valid slot is necessarily older than a slot already being recovered.
  assign misFire   = misReq && valid_q[res_tag_i];
  assign gnt       = alloc_req_i && !full && (state_q == IDLE) && !misReq;
  assign resOH     = ONE << res_tag_i;
  assign clearOH   = clearFire ? resOH : '0;
  assign allocDep  = valid_q & ~clearOH;

  always_comb begin
    freeTag = '0;
    for (int i = N_CHECKPTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) freeTag = TAG_W'(i);
    end
  end

  // Younger slots are exactly those whose row marks the resolving slot as older.
  always_comb begin
    squash = resOH;
    for (int j = 0; j < N_CHECKPTS; j++) begin
      if (dep_q[j][res_tag_i]) squash[j] = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int j = 0; j < N_CHECKPTS; j++) dep_d[j] = dep_q[j];
    if (clearFire) begin
      valid_d = valid_d & ~resOH;
      for (int j = 0; j < N_CHECKPTS; j++) dep_d[j] = dep_d[j] & ~resOH;
      dep_d[res_tag_i] = '0;
    end
    if (misFire) begin
      valid_d = valid_d & ~squash;
      for (int j = 0; j < N_CHECKPTS; j++) begin
        dep_d[j] = squash[j] ? '0 : (dep_d[j] & ~squash);
      end
    end
    if (gnt) begin
      valid_d[freeTag] = 1'b1;
      dep_d[freeTag]   = allocDep;
    end
    clearValid_d = clearFire;
    clearTag_d   = clearFire ? res_tag_i : '0;
    recoverTag_d = misFire ? res_tag_i : '0;
    squashMask_d = misFire ? squash : '0;
  end

  always_comb begin
    state_d    = state_q;
    flushCnt_d = flushCnt_q;
    case (state_q)
      IDLE: ;
      RECOVER: begin
        state_d    = FLUSH;
        flushCnt_d = CNT_W'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (flushCnt_q == '0) state_d = IDLE;
        else flushCnt_d = flushCnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (misFire) state_d = RECOVER;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      flushCnt_q   <= '0;
      valid_q      <= '0;
      for (int j = 0; j < N_CHECKPTS; j++) dep_q[j] <= '0;
      clearValid_q <= 1'b0;
      clearTag_q   <= '0;
      recoverTag_q <= '0;
      squashMask_q <= '0;
    end else begin
      state_q      <= state_d;
      flushCnt_q   <= flushCnt_d;
      valid_q      <= valid_d;
      for (int j = 0; j < N_CHECKPTS; j++) dep_q[j] <= dep_d[j];
      clearValid_q <= clearValid_d;
      clearTag_q   <= clearTag_d;
      recoverTag_q <= recoverTag_d;
      squashMask_q <= squashMask_d;
    end
  end

  assign alloc_gnt_o   = gnt;
  assign alloc_tag_o   = freeTag;
  assign alloc_dep_o   = allocDep;
  assign clear_valid_o = clearValid_q;
  assign clear_tag_o   = clearTag_q;
  assign recover_o     = (state_q == RECOVER);
  assign recover_tag_o = recoverTag_q;
  assign squash_mask_o = squashMask_q;
  assign busy_o        = (state_q != IDLE);
  assign valid_mask_o  = valid_q;
  assign full_o        = full;

`ifdef CKPT_SCHED_STATS_EN
  logic [31:0] statAlloc_q, statMis_q, statFull_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      statAlloc_q <= '0;
      statMis_q   <= '0;
      statFull_q  <= '0;
    end else begin
      if (gnt && statAlloc_q != '1) statAlloc_q <= statAlloc_q + 32'd1;
      if (misFire && statMis_q != '1) statMis_q <= statMis_q + 32'd1;
      if (alloc_req_i && full && statFull_q != '1) statFull_q <= statFull_q + 32'd1;
    end
  end

  assign stat_alloc_o      = statAlloc_q;
  assign stat_mispredict_o = statMis_q;
  assign stat_full_stall_o = statFull_q;
`endif

endmodule

// File: tb/tb_ckpt_scheduler.sv
// Scoreboard bench for ckpt_scheduler: an age-ordered slot list predicts grants, clears and recoveries.
module tb_ckpt_scheduler;

  localparam int N  = 8;
  localparam int TW = 3;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_req_i = 1'b0;
  logic          alloc_gnt_o;
  logic [TW-1:0] alloc_tag_o;
  logic [N-1:0]  alloc_dep_o;
  logic          res_valid_i = 1'b0;
  logic [TW-1:0] res_tag_i = '0;
  logic          res_mispredict_i = 1'b0;
  logic          clear_valid_o;
  logic [TW-1:0] clear_tag_o;
  logic          recover_o;
  logic [TW-1:0] recover_tag_o;
  logic [N-1:0]  squash_mask_o;
  logic          busy_o;
  logic [N-1:0]  valid_mask_o;
  logic          full_o;
`ifdef CKPT_SCHED_STATS_EN
  logic [31:0]   stat_alloc_o, stat_mispredict_o, stat_full_stall_o;
`endif

  ckpt_scheduler #(.N_CHECKPTS(N), .TAG_W(TW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_tag_o(alloc_tag_o),
    .alloc_dep_o(alloc_dep_o), .res_valid_i(res_valid_i), .res_tag_i(res_tag_i),
    .res_mispredict_i(res_mispredict_i), .clear_valid_o(clear_valid_o), .clear_tag_o(clear_tag_o),
    .recover_o(recover_o), .recover_tag_o(recover_tag_o), .squash_mask_o(squash_mask_o),
    .busy_o(busy_o), .valid_mask_o(valid_mask_o), .full_o(full_o)
`ifdef CKPT_SCHED_STATS_EN
    , .stat_alloc_o(stat_alloc_o), .stat_mispredict_o(stat_mispredict_o),
    .stat_full_stall_o(stat_full_stall_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int stamp; logic [TW-1:0] tag; logic [N-1:0] mask; } exp_t;
  typedef struct { int stamp; logic [N-1:0] valid; logic busy; logic full; } cyc_t;

  exp_t allocQ[$];
  exp_t clearQ[$];
  exp_t recoverQ[$];
  cyc_t cycQ[$];

  // Reference model: in-flight tags listed oldest first.
  int ageQ[$];
  int busyRem = 0;
  int unsigned mAlloc = 0, mMis = 0, mFull = 0;

  int vecs = 0;
  int errs = 0;
  bit monOn = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] modelMask();
    logic [N-1:0] m = '0;
    foreach (ageQ[i]) m[ageQ[i]] = 1'b1;
    return m;
  endfunction

  function automatic int findIdx(input int t);
    foreach (ageQ[i]) if (ageQ[i] == t) return i;
    return -1;
  endfunction

  task automatic applyStimulus(input bit req, input bit rv, input int rt, input bit rm);
    logic [N-1:0] pre, sq;
    int idx, tag;
    bit clr, mis, gnt;
    exp_t e;
    cyc_t c;
    alloc_req_i      = req;
    res_valid_i      = rv;
    res_tag_i        = rt[TW-1:0];
    res_mispredict_i = rm;
    pre = modelMask();
    c.stamp = cyc; c.valid = pre; c.busy = (busyRem > 0); c.full = (ageQ.size() == N);
    cycQ.push_back(c);
    idx = rv ? findIdx(rt) : -1;
    clr = rv && !rm && idx >= 0;
    mis = rv && rm && idx >= 0;
    gnt = req && ageQ.size() < N && busyRem == 0 && !(rv && rm);
    tag = 0;
    if (gnt) begin
      for (int t = N - 1; t >= 0; t--) if (!pre[t]) tag = t;
      e.stamp = cyc; e.tag = tag[TW-1:0];
      e.mask = pre & ~(clr ? (N'(1) << rt) : N'(0));
      allocQ.push_back(e);
      mAlloc++;
    end
    if (req && ageQ.size() == N) mFull++;
    if (busyRem > 0) busyRem--;
    if (clr) begin
      e.stamp = cyc + 1; e.tag = rt[TW-1:0]; e.mask = '0;
      clearQ.push_back(e);
      ageQ.delete(idx);
    end
    if (mis) begin
      sq = '0;
      for (int k = idx; k < ageQ.size(); k++) sq[ageQ[k]] = 1'b1;
      e.stamp = cyc + 1; e.tag = rt[TW-1:0]; e.mask = sq;
      recoverQ.push_back(e);
      while (ageQ.size() > idx) void'(ageQ.pop_back());
      busyRem = 1 + FC;
      mMis++;
    end
    if (gnt) ageQ.push_back(tag);
    @(posedge clk); #1;
  endtask

  task automatic applyReset(input int n);
    rst = 1'b1; alloc_req_i = 1'b0; res_valid_i = 1'b0; res_mispredict_i = 1'b0; res_tag_i = '0;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
    ageQ.delete(); allocQ.delete(); clearQ.delete(); recoverQ.delete(); cycQ.delete();
    busyRem = 0; mAlloc = 0; mMis = 0; mFull = 0;
    cmp("rst_valid_mask", valid_mask_o, 0);
    cmp("rst_busy", busy_o, 0);
    cmp("rst_recover", recover_o, 0);
    cmp("rst_alloc_tag", alloc_tag_o, 0);
    cmp("rst_clear_valid", clear_valid_o, 0);
`ifdef CKPT_SCHED_STATS_EN
    cmp("rst_stat_alloc", stat_alloc_o, 0);
    cmp("rst_stat_mis", stat_mispredict_o, 0);
    cmp("rst_stat_full", stat_full_stall_o, 0);
`endif
  endtask

  task automatic checkOutput();
    exp_t e;
    cyc_t c;
    bit ex;
    ex = (allocQ.size() > 0 && allocQ[0].stamp == cyc);
    cmp("alloc_gnt", alloc_gnt_o, ex);
    if (ex) begin
      e = allocQ.pop_front();
      if (alloc_gnt_o) begin
        cmp("alloc_tag", alloc_tag_o, e.tag);
        cmp("alloc_dep", alloc_dep_o, e.mask);
      end
    end
    ex = (clearQ.size() > 0 && clearQ[0].stamp == cyc);
    cmp("clear_valid", clear_valid_o, ex);
    if (ex) begin
      e = clearQ.pop_front();
      if (clear_valid_o) cmp("clear_tag", clear_tag_o, e.tag);
    end
    ex = (recoverQ.size() > 0 && recoverQ[0].stamp == cyc);
    cmp("recover", recover_o, ex);
    if (ex) begin
      e = recoverQ.pop_front();
      if (recover_o) begin
        cmp("recover_tag", recover_tag_o, e.tag);
        cmp("squash_mask", squash_mask_o, e.mask);
      end
    end
    if (cycQ.size() > 0 && cycQ[0].stamp == cyc) begin
      c = cycQ.pop_front();
      cmp("valid_mask", valid_mask_o, c.valid);
      cmp("busy", busy_o, c.busy);
      cmp("full", full_o, c.full);
    end
  endtask

  always @(negedge clk) if (monOn) checkOutput();

  initial begin
    int rt;
    applyReset(2);
    monOn = 1'b1;

    // Three back-to-back allocations
    repeat (3) applyStimulus(1, 0, 0, 0);
    cmp("plan_valid_3", valid_mask_o, 'h07);

    // Fill, overflow request, retire 3, reuse 3
    applyReset(1);
    repeat (8) applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    cmp("plan_full", full_o, 1);
    applyStimulus(0, 1, 3, 0);
    cmp("plan_clear_tag", clear_tag_o, 3);
    applyStimulus(1, 0, 0, 0);
    cmp("plan_realloc", valid_mask_o, 'hFF);

    // Mispredict 2 with 0..4 live, nested mispredict 0 in FLUSH, stale resolve of 4
    applyReset(1);
    repeat (5) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 2, 1);
    cmp("plan_rec_tag", recover_tag_o, 2);
    cmp("plan_squash", squash_mask_o, 'h1C);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1);
    cmp("plan_rec_tag2", recover_tag_o, 0);
    cmp("plan_squash2", squash_mask_o, 'h03);
    applyStimulus(0, 1, 4, 0);
    repeat (5) applyStimulus(1, 0, 0, 0);

    // Same-cycle alloc and correct resolve
    applyReset(1);
    repeat (2) applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0);
    cmp("plan_same_cycle", valid_mask_o, 'h05);

    // Reset while flushing
    applyReset(1);
    repeat (3) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0);
    applyReset(1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        applyReset(1);
      end else begin
        if (ageQ.size() > 0 && $urandom_range(0, 3) != 0)
          rt = ageQ[$urandom_range(0, ageQ.size() - 1)];
        else
          rt = $urandom_range(0, N - 1);
        applyStimulus($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 45, rt,
                      $urandom_range(0, 99) < 20);
      end
    end
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
`ifdef CKPT_SCHED_STATS_EN
    cmp("stat_alloc", stat_alloc_o, mAlloc);
    cmp("stat_mis", stat_mispredict_o, mMis);
    cmp("stat_full", stat_full_stall_o, mFull);
`endif
    @(negedge clk);
    monOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
